// File: rtl/register_file_pkg.sv
// Shared types and helpers for the register-file family: sweep state encoding and
// the byte-lane merge used by every byte-enabled write port.
package register_file_pkg;

    typedef enum logic [0:0] {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } sweep_state_e;

    // Widest word any variant may use; callers zero-extend in and truncate out.
    localparam int unsigned MAX_DATA_WIDTH = 1024;
    localparam int unsigned MAX_BYTES      = MAX_DATA_WIDTH / 8;

    function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_BYTES-1:0]      mask
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (mask[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/register_file_clear_sequencer.sv
// Clear sweep sequencer: walks a zero-write over every entry after reset or on a
// clear request, one entry per clock, and flags the file busy meanwhile.
module register_file_clear_sequencer
    import register_file_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    output logic                  busy,
    output logic                  clear_we,
    output logic [ADDR_WIDTH-1:0] clear_addr
);

    sweep_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            SWEEP: begin
                // A clear request mid-sweep is deliberately ignored.
                ptr_d = ptr_q + ADDR_WIDTH'(1);
                if (ptr_q == '1) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end
            end
            IDLE: begin
                if (clear) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = SWEEP;
                ptr_d   = '0;
            end
        endcase
    end

    assign busy       = (state_q == SWEEP);
    assign clear_we   = busy;
    assign clear_addr = ptr_q;

endmodule

// File: rtl/multi_read_register_file.sv
// Register file with one byte-enabled write port, N_READ write-first read ports and a
// sequenced clear; read data is forced to zero while the clear sweep is running.
module multi_read_register_file
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 8,
    parameter int unsigned N_READ          = 2,
    parameter int unsigned REGISTERED_READ = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic [ADDR_WIDTH-1:0]        addr_w,
    input  logic                         we,
    input  logic [DATA_WIDTH/8-1:0]      byte_en,
    input  logic [N_READ*ADDR_WIDTH-1:0] addr_r,
    output logic [N_READ*DATA_WIDTH-1:0] q,
    input  logic                         clear,
    output logic                         clear_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] ram [DEPTH];

    logic                  clear_we;
    logic [ADDR_WIDTH-1:0] clear_addr;
    logic                  user_we;
    logic [DATA_WIDTH-1:0] merged_w;

    register_file_clear_sequencer #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_seq (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .busy       (clear_busy),
        .clear_we   (clear_we),
        .clear_addr (clear_addr)
    );

    // User writes lose to both the sweep and a same-cycle clear request.
    assign user_we = we & ~clear_busy & ~clear;

    assign merged_w = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(ram[addr_w]),
                                             MAX_DATA_WIDTH'(data_in),
                                             MAX_BYTES'(byte_en)));

    // Storage has no reset; the sweep and the busy read mask cover initial contents.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            ram[clear_addr] <= '0;
        end else if (user_we) begin
            ram[addr_w] <= merged_w;
        end
    end

    for (genvar p = 0; p < N_READ; p++) begin : g_read
        logic [ADDR_WIDTH-1:0] rd_addr;
        logic [DATA_WIDTH-1:0] rd_data;

        assign rd_addr = addr_r[p*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rd_data = ram[rd_addr];
            if (clear_busy) begin
                rd_data = '0;
            end else if (user_we && (addr_w == rd_addr)) begin
                rd_data = merged_w;
            end
        end

        if (REGISTERED_READ != 0) begin : g_reg
            logic [DATA_WIDTH-1:0] q_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    q_q <= '0;
                end else begin
                    q_q <= rd_data;
                end
            end

            assign q[p*DATA_WIDTH +: DATA_WIDTH] = q_q;
        end else begin : g_comb
            assign q[p*DATA_WIDTH +: DATA_WIDTH] = rd_data;
        end
    end

endmodule

// File: tb/tb_multi_read_register_file.sv
// Directed bench: one combinational and one registered instance share all inputs.
module tb_multi_read_register_file;

    logic        clk;
    logic        reset;
    logic [31:0] data_in;
    logic [3:0]  addr_w;
    logic        we;
    logic [3:0]  byte_en;
    logic [11:0] addr_r;
    logic        clear;
    logic [95:0] q_c;
    logic [95:0] q_r;
    logic        busy_c;
    logic        busy_r;

    int n_vec  = 0;
    int n_miss = 0;

    multi_read_register_file #(
        .DATA_WIDTH      (32),
        .ADDR_WIDTH      (4),
        .N_READ          (3),
        .REGISTERED_READ (0)
    ) u_dut_comb (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .addr_w     (addr_w),
        .we         (we),
        .byte_en    (byte_en),
        .addr_r     (addr_r),
        .q          (q_c),
        .clear      (clear),
        .clear_busy (busy_c)
    );

    multi_read_register_file #(
        .DATA_WIDTH      (32),
        .ADDR_WIDTH      (4),
        .N_READ          (3),
        .REGISTERED_READ (1)
    ) u_dut_reg (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .addr_w     (addr_w),
        .we         (we),
        .byte_en    (byte_en),
        .addr_r     (addr_r),
        .q          (q_r),
        .clear      (clear),
        .clear_busy (busy_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        we      = 1'b1;
        addr_w  = a;
        data_in = d;
        byte_en = be;
        tick();
        we      = 1'b0;
        byte_en = 4'h0;
    endtask

    task automatic rd_all(input logic [3:0] a);
        addr_r = {a, a, a};
        #1;
    endtask

    task automatic count_busy(input string tag);
        int n;
        n = 0;
        while (busy_c && n < 40) begin
            tick();
            n++;
        end
        check(tag, 96'(n), 96'd16);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        reset   = 1'b1;
        data_in = '0;
        addr_w  = '0;
        we      = 1'b0;
        byte_en = '0;
        addr_r  = '0;
        clear   = 1'b0;
        #2 reset = 1'b0;
        tick();
        tick();
        check("rst_busy", 96'(busy_c), 96'd1);
        check("rst_q_comb", q_c, 96'd0);
        check("rst_q_reg", q_r, 96'd0);

        reset = 1'b1;
        count_busy("sweep_len_after_reset");
        for (int i = 0; i < 16; i++) begin
            rd_all(4'(i));
            check("post_reset_zero", q_c, 96'd0);
        end
        tick();
        check("post_reset_zero_reg", q_r, 96'd0);

        // Full write then low-half byte update on addr 3, with same-cycle bypass.
        addr_r  = {4'd3, 4'd3, 4'd3};
        we      = 1'b1;
        addr_w  = 4'd3;
        data_in = 32'hDEADBEEF;
        byte_en = 4'b1111;
        #1;
        check("bypass_full", q_c, {3{32'hDEADBEEF}});
        tick();
        data_in = 32'h00001234;
        byte_en = 4'b0011;
        #1;
        check("bypass_partial", q_c, {3{32'hDEAD1234}});
        check("reg_bypass_full", q_r, {3{32'hDEADBEEF}});
        tick();
        we = 1'b0;
        #1;
        check("merge_stored", q_c, {3{32'hDEAD1234}});
        check("reg_bypass_partial", q_r, {3{32'hDEAD1234}});

        we      = 1'b1;
        byte_en = 4'b0000;
        data_in = 32'hFFFFFFFF;
        tick();
        we = 1'b0;
        #1;
        check("be_zero_noop", q_c, {3{32'hDEAD1234}});

        // Ports 0/2 on the written address, port 1 on a stored neighbour.
        wr(4'd6, 32'h66666666, 4'hF);
        addr_r  = {4'd5, 4'd6, 4'd5};
        we      = 1'b1;
        addr_w  = 4'd5;
        data_in = 32'hCAFEF00D;
        byte_en = 4'hF;
        #1;
        check("multi_port_bypass", q_c, {32'hCAFEF00D, 32'h66666666, 32'hCAFEF00D});
        tick();
        we = 1'b0;
        #1;
        check("multi_port_reg", q_r, {32'hCAFEF00D, 32'h66666666, 32'hCAFEF00D});
        check("multi_port_stored", q_c, {32'hCAFEF00D, 32'h66666666, 32'hCAFEF00D});
        we      = 1'b1;
        byte_en = 4'b0100;
        data_in = 32'h00AB0000;
        #1;
        check("multi_port_byte2", q_c, {32'hCAABF00D, 32'h66666666, 32'hCAABF00D});
        tick();
        we      = 1'b0;
        byte_en = 4'h0;

        // Clear with a colliding write; second clear and a write land mid-sweep.
        wr(4'd2, 32'h22222222, 4'hF);
        addr_r  = {4'd2, 4'd2, 4'd2};
        clear   = 1'b1;
        we      = 1'b1;
        addr_w  = 4'd2;
        data_in = 32'h99999999;
        byte_en = 4'hF;
        #1;
        check("clear_cycle_no_bypass", q_c, {3{32'h22222222}});
        tick();
        clear = 1'b0;
        we    = 1'b0;
        check("clear_busy_rise", 96'(busy_c), 96'd1);
        addr_r = {4'd3, 4'd3, 4'd3};
        n = 0;
        while (busy_c && n < 40) begin
            if (n == 3) begin
                check("busy_masks_read", q_c, 96'd0);
            end
            clear   = (n == 5);
            we      = (n == 12);
            addr_w  = 4'd9;
            data_in = 32'h11111111;
            byte_en = 4'hF;
            tick();
            n++;
        end
        clear = 1'b0;
        we    = 1'b0;
        check("clear_sweep_len", 96'(n), 96'd16);
        rd_all(4'd2);
        check("clear_dropped_write", q_c, 96'd0);
        rd_all(4'd9);
        check("sweep_dropped_write", q_c, 96'd0);
        rd_all(4'd3);
        check("clear_zeroed", q_c, 96'd0);

        // Reset seven cycles into a sweep restarts it in full.
        wr(4'd4, 32'h44444444, 4'hF);
        rd_all(4'd4);
        check("pre_reset_write", q_c, {3{32'h44444444}});
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (7) tick();
        reset = 1'b0;
        #1;
        check("midsweep_reset_busy", 96'(busy_c), 96'd1);
        check("midsweep_reset_q_comb", q_c, 96'd0);
        check("midsweep_reset_q_reg", q_r, 96'd0);
        tick();
        tick();
        check("midsweep_reset_hold", 96'(busy_c), 96'd1);
        reset = 1'b1;
        count_busy("sweep_len_after_midreset");
        wr(4'd7, 32'h77777777, 4'hF);
        rd_all(4'd7);
        check("first_write_after_sweep", q_c, {3{32'h77777777}});
        rd_all(4'd4);
        check("midreset_zeroed", q_c, 96'd0);
        tick();
        check("midreset_zeroed_reg", q_r, 96'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/multi_read_register_file.md
# multi_read_register_file

Parametrised register file with one byte-enabled write port and N_READ independent read ports, each with write-first bypass. Reads are combinational or registered (selectable). An internal clear sequencer zeroes the storage one entry per cycle after reset or on request, so no array-wide reset fan-out is needed. Used as the operand/state store for control cores and as a shared parameter bank between datapath stages.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8
- ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH
- N_READ, 2, number of read ports, 1..8
- REGISTERED_READ, 0, 0 = combinational read outputs, 1 = read outputs registered (1-cycle latency)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- data_in  in  DATA_WIDTH  write data
- addr_w  in  ADDR_WIDTH  write address
- we  in  1  write enable
- byte_en  in  DATA_WIDTH/8  per-byte write mask; bit k covers data bits [8k+7:8k]
- addr_r  in  N_READ*ADDR_WIDTH  read addresses; port p at bits [p*ADDR_WIDTH +: ADDR_WIDTH]
- q  out  N_READ*DATA_WIDTH  read data; port p at bits [p*DATA_WIDTH +: DATA_WIDTH]
- clear  in  1  single-cycle request to zero the whole file
- clear_busy  out  1  high while the clear sweep is in progress

## Operation
- States: SWEEP, IDLE. Reset (asynchronous) forces SWEEP, clear pointer = 0, clear_busy = 1, registered q = 0.
- SWEEP: each clock writes 0 to ram[ptr], ptr increments; the edge that clears entry 2**ADDR_WIDTH-1 moves to IDLE and drops clear_busy.
- IDLE: clear = 1 -> SWEEP with ptr = 0. clear while in SWEEP is ignored (no restart).
- Writes: in IDLE with we = 1 and clear = 0, ram[addr_w] byte k <= data_in byte k where byte_en[k] = 1; other bytes kept. byte_en = 0 with we = 1 is a no-op.
- Writes in SWEEP, or in the IDLE cycle where clear = 1, are dropped.
- Read data per port p: while clear_busy = 1, 0. Otherwise, if an accepted write targets addr_r[p] in the same cycle, the merged word (new bytes where byte_en set, stored bytes elsewhere); else ram[addr_r[p]].
- All ports may read the same address simultaneously; each gets identical data.
- Storage itself is not reset; only the sequencer, registered q and clear_busy are.

## Timing
- REGISTERED_READ = 0: q is combinational from addr_r, we, addr_w, byte_en, data_in and state; bypass visible in the write cycle.
- REGISTERED_READ = 1: q updates on the rising edge after addresses are presented; value equals what REGISTERED_READ = 0 would show in that cycle (bypass included). Reset value 0.
- After reset release, clear_busy stays high for exactly 2**ADDR_WIDTH rising edges; first write accepted on the following cycle.
- clear pulse in IDLE: clear_busy high from the next edge for 2**ADDR_WIDTH cycles.
- Reset asserted mid-sweep or mid-write: sweep restarts from 0 on release; partially swept contents undefined until sweep completes (masked by the busy read rule).

## Structure
- Package register_file_pkg: sweep state enum (SWEEP, IDLE) and byte-merge helper function (old word, new word, mask -> merged word), shared with other register-file variants.
- Sub-module register_file_clear_sequencer: state, pointer, clear_busy, clear-write strobe/address; the top muxes its write over the user write port.
- Read ports generated with a generate loop over N_READ.

## Test plan
- ADDR_WIDTH=4: release reset -> clear_busy high exactly 16 cycles, all q = 0; then read all 16 addresses -> 0.
- Write 0xDEADBEEF to addr 3 with byte_en=4'b1111, next cycle write 0x00001234 with byte_en=4'b0011 -> q at addr 3 reads 0xDEAD1234.
- N_READ=3, port 0 and port 2 read addr 5 while writing 0xCAFEF00D to addr 5, port 1 reads addr 6 -> ports 0/2 show 0xCAFEF00D in the same cycle (comb) or next edge (registered); port 1 shows stored addr 6.
- clear pulse in IDLE with simultaneous write to addr 2 -> write dropped, sweep runs 16 cycles, addr 2 reads 0 afterwards; second clear pulse mid-sweep does not extend busy.
- Write during SWEEP to addr 9 with 0x11111111 -> dropped; addr 9 reads 0 after busy falls.
- Assert reset at sweep cycle 7 -> clear_busy stays 1, q = 0; after release full 16-cycle sweep.
